// File: rtl/datapath_seq_ctrl_if.sv
// Command, result and datapath-side signals of the add/sub sequencer.
// The slave view belongs to the sequencer; master is the surrounding environment.
interface datapath_seq_ctrl_if #(
  parameter int N     = 16,
  parameter int REP_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [N-1:0]     cmd_a;
  logic [N-1:0]     cmd_b;
  logic             cmd_acc;
  logic [REP_W-1:0] cmd_rep;
  logic             acc_clr;
  logic [N-1:0]     dp_a;
  logic [N-1:0]     dp_b;
  logic [2:0]       dp_opcode;
  logic [N-1:0]     dp_y;
  logic             dp_co;
  logic             res_valid;
  logic             res_ready;
  logic [N-1:0]     res_y;
  logic             res_co;
  logic             res_cov;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_acc, cmd_rep, acc_clr,
    input  dp_y, dp_co, res_ready,
    output cmd_ready, dp_a, dp_b, dp_opcode, res_valid, res_y, res_co, res_cov
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_acc, cmd_rep, acc_clr,
    output dp_y, dp_co, res_ready,
    input  cmd_ready, dp_a, dp_b, dp_opcode, res_valid, res_y, res_co, res_cov
  );
endinterface

// File: rtl/datapath_seq_ctrl.sv
// Sequencer for an external add/sub datapath: repeats one opcode cmd_rep+1 times,
// feeding Y back into A, and hands the final Y plus carry flags to a result port.
module datapath_seq_ctrl #(
  parameter int N     = 16,
  parameter int REP_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  datapath_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [N-1:0]     acc;
  logic [REP_W-1:0] count;
  logic [N-1:0]     dp_a;
  logic [N-1:0]     dp_b;
  logic [2:0]       dp_opcode;
  logic [N-1:0]     res_y;
  logic             res_co;
  logic             res_cov;
  logic             res_valid;
  logic             accept;

  // Ready is gated by rst_n so no command can be taken during a reset cycle.
  assign bus.cmd_ready = (state == IDLE) && rst_n;
  assign accept        = bus.cmd_valid && bus.cmd_ready;

  assign bus.dp_a      = dp_a;
  assign bus.dp_b      = dp_b;
  assign bus.dp_opcode = dp_opcode;
  assign bus.res_y     = res_y;
  assign bus.res_co    = res_co;
  assign bus.res_cov   = res_cov;
  assign bus.res_valid = res_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    if (count == '0) state_next = DONE;
      DONE:    if (bus.res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dp_a      <= '0;
      dp_b      <= '0;
      dp_opcode <= 3'b000;
      res_y     <= '0;
      res_co    <= 1'b0;
      res_cov   <= 1'b0;
      res_valid <= 1'b0;
      acc       <= '0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A clear coinciding with an accept takes effect before cmd_acc reads acc.
          if (bus.acc_clr) acc <= '0;
          if (accept) begin
            dp_a      <= bus.cmd_acc ? (bus.acc_clr ? '0 : acc) : bus.cmd_a;
            dp_b      <= bus.cmd_b;
            dp_opcode <= bus.cmd_op;
            count     <= bus.cmd_rep;
            res_cov   <= 1'b0;
          end
        end
        EXEC: begin
          dp_a    <= bus.dp_y;
          res_y   <= bus.dp_y;
          res_co  <= bus.dp_co;
          res_cov <= res_cov | bus.dp_co;
          if (count != '0) begin
            count <= count - 1'b1;
          end else begin
            res_valid <= 1'b1;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            acc       <= res_y;
            res_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
